// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and default sizing for the fetch sequencer.
// The optional retire counter is enabled with the FETCH_PERF_EN macro (see fetch_sequencer).
package fetch_pkg;

    localparam int FETCH_ADDR_W = 6;
    localparam int FETCH_DATA_W = 32;
    localparam int FETCH_DEPTH  = 64;

    // Raw encodings kept as plain constants so older code can compare against them directly.
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FETCH  = 2'd1;
    localparam logic [1:0] S_ISSUE  = 2'd2;
    localparam logic [1:0] S_HALTED = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = S_IDLE,
        ST_FETCH  = S_FETCH,
        ST_ISSUE  = S_ISSUE,
        ST_HALTED = S_HALTED
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_next.sv
// fetch_pc_next: combinational next-PC select.
// Sequential increment wraps at DEPTH-1; a redirect to an address at or
// beyond DEPTH is clamped to 0 and flagged through range_err.
module fetch_pc_next #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [ADDR_W-1:0] next_pc,
    output logic              range_err
);

    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(DEPTH-1);

    // Pick redirect target or sequential successor, clamping bad targets to 0.
    always_comb begin
        range_err = 1'b0;
        next_pc   = (pc == LAST_PC) ? '0 : pc + ADDR_W'(1);
        if (redirect_valid) begin
            if ({1'b0, redirect_addr} >= DEPTH_C) begin
                next_pc   = '0;
                range_err = 1'b1;
            end else begin
                next_pc = redirect_addr;
            end
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, issues imem reads over req/ack and hands
// each instruction to decode over valid/ready. Redirects apply only on the
// hand-off cycle. Define FETCH_PERF_EN to build the 16-bit retire counter;
// otherwise retired_cnt is tied to 0.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int ADDR_W = FETCH_ADDR_W,
    parameter int DATA_W = FETCH_DATA_W,
    parameter int DEPTH  = FETCH_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              halt_req,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              busy,
    output logic              addr_err,
    output logic [15:0]       retired_cnt
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] next_pc;
    logic              range_err;
    logic              handoff;

    assign handoff = (state == ST_ISSUE) && instr_ready;

    fetch_pc_next #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_pc_next (
        .pc             (pc),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .next_pc        (next_pc),
        .range_err      (range_err)
    );

    // All outputs decode from registered state, never from inputs.
    assign imem_req    = (state == ST_FETCH);
    assign instr_valid = (state == ST_ISSUE);
    assign busy        = (state == ST_FETCH) || (state == ST_ISSUE);
    assign imem_addr   = pc;

    // Control FSM plus PC / instruction capture registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            pc       <= '0;
            instr    <= '0;
            instr_pc <= '0;
            addr_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_HALTED: begin
                    if (run) state <= ST_FETCH;
                end
                ST_FETCH: begin
                    // halt_req is deliberately not looked at here: an issued read always completes.
                    if (imem_ack) begin
                        instr    <= imem_rdata;
                        instr_pc <= pc;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (handoff) begin
                        pc <= next_pc;
                        if (range_err) addr_err <= 1'b1;
                        state <= halt_req ? ST_HALTED : ST_FETCH;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic [15:0] retired_q;

    // Count hand-offs; wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (reset)        retired_q <= '0;
        else if (handoff) retired_q <= retired_q + 16'd1;
    end

    assign retired_cnt = retired_q;
`else
    assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed stimulus with a hand-off scoreboard.
// Stimulus pushes the PC it expects to be handed to decode; a negedge
// monitor pops and compares on every valid&&ready cycle.
module tb_fetch_sequencer;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int DP = 40;

    logic          clk = 1'b0;
    logic          reset, run, halt_req;
    logic          imem_req, imem_ack;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_rdata;
    logic          instr_valid, instr_ready;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          redirect_valid;
    logic [AW-1:0] redirect_addr;
    logic          busy, addr_err;
    logic [15:0]   retired_cnt;

    int vectors = 0;
    int miscompares = 0;
    int n_ho = 0;
    int ack_wait = 0;
    int wait_cnt = 0;
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] mon_pc;

    always #5 clk = ~clk;

    fetch_sequencer #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DP)) dut (
        .clk(clk), .reset(reset), .run(run), .halt_req(halt_req),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .busy(busy), .addr_err(addr_err), .retired_cnt(retired_cnt)
    );

    function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
        return {16'hC0DE, 10'h0, a};
    endfunction

    // Memory responder: ack after ack_wait request cycles, data from address.
    assign imem_ack   = imem_req && (wait_cnt >= ack_wait);
    assign imem_rdata = word(imem_addr);
    always @(posedge clk) begin
        if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
        else                       wait_cnt <= 0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Hand-off monitor.
    always @(negedge clk) begin
        if (!reset && instr_valid && instr_ready) begin
            n_ho++;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL sb_unexpected: got instr_pc %h expected no hand-off", instr_pc);
            end else begin
                mon_pc = exp_q.pop_front();
                chk("sb_instr_pc", 32'(instr_pc), 32'(mon_pc));
                chk("sb_instr", instr, word(mon_pc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Precondition: FETCH at p, zero-wait memory, decoder ready.
    task automatic issue_one(input logic [AW-1:0] p, input logic redir,
                             input logic [AW-1:0] raddr, input logic hlt);
        exp_q.push_back(p);
        chk("fetch_req", 32'(imem_req), 32'd1);
        chk("fetch_addr", 32'(imem_addr), 32'(p));
        tick();
        chk("issue_valid", 32'(instr_valid), 32'd1);
        redirect_valid = redir;
        redirect_addr  = raddr;
        halt_req       = hlt;
        tick();
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        halt_req       = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; run = 1'b0; halt_req = 1'b0; instr_ready = 1'b1;
        redirect_valid = 1'b0; redirect_addr = '0;
        tick(); tick();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", 32'(instr_pc), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addr_err", 32'(addr_err), 32'd0);
        chk("rst_retired", 32'(retired_cnt), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        reset = 1'b0;
        tick();
        chk("idle_no_req", 32'(imem_req), 32'd0);

        // Zero-wait streaming 0..3, halt after 3.
        run = 1'b1;
        tick();
        run = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("stream_valid_low", 32'(instr_valid), 32'd0);
            issue_one(AW'(i), 1'b0, '0, i == 3);
        end
        chk("halt_req_low", 32'(imem_req), 32'd0);
        chk("halt_busy", 32'(busy), 32'd0);
        tick();
        chk("halt_stays", 32'(imem_req), 32'd0);

        // Resume at retained pc, halt at 7, resume to 8.
        run = 1'b1;
        tick();
        run = 1'b0;
        for (int i = 4; i < 8; i++) issue_one(AW'(i), 1'b0, '0, i == 7);
        chk("halt7_req", 32'(imem_req), 32'd0);
        chk("halt7_busy", 32'(busy), 32'd0);
        run = 1'b1;
        tick();
        run = 1'b0;
        chk("resume_addr", 32'(imem_addr), 32'd8);

        // Redirects, wrap at DEPTH-1, out-of-range clamp.
        issue_one(6'd8, 1'b1, 6'd5, 1'b0);
        issue_one(6'd5, 1'b1, 6'd20, 1'b0);
        chk("redir_addr", 32'(imem_addr), 32'd20);
        for (int i = 20; i < 40; i++) issue_one(AW'(i), 1'b0, '0, 1'b0);
        chk("wrap_addr", 32'(imem_addr), 32'd0);
        chk("wrap_no_err", 32'(addr_err), 32'd0);
        issue_one(6'd0, 1'b1, 6'd39, 1'b0);
        chk("redir_last_ok", 32'(addr_err), 32'd0);
        issue_one(6'd39, 1'b0, '0, 1'b0);
        issue_one(6'd0, 1'b1, 6'd45, 1'b0);
        chk("oor_addr", 32'(imem_addr), 32'd0);
        chk("oor_err", 32'(addr_err), 32'd1);
        issue_one(6'd0, 1'b0, '0, 1'b0);
        chk("err_sticky", 32'(addr_err), 32'd1);

        // Slow memory (ack after 3 waits) and stalled decoder.
        ack_wait = 3;
        exp_q.push_back(6'd1);
        for (int i = 0; i < 4; i++) begin
            chk("slow_req", 32'(imem_req), 32'd1);
            chk("slow_addr", 32'(imem_addr), 32'd1);
            chk("slow_valid_low", 32'(instr_valid), 32'd0);
            tick();
        end
        ack_wait = 0;
        chk("slow_valid", 32'(instr_valid), 32'd1);
        instr_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_addr = 6'd30;
        tick();
        tick();
        chk("stall_valid", 32'(instr_valid), 32'd1);
        chk("stall_instr", instr, word(6'd1));
        chk("stall_instr_pc", 32'(instr_pc), 32'd1);
        redirect_valid = 1'b0;
        instr_ready = 1'b1;
        tick();
        chk("no_stray_redir", 32'(imem_addr), 32'd2);
        for (int i = 2; i < 12; i++) issue_one(AW'(i), 1'b0, '0, 1'b0);
`ifdef FETCH_PERF_EN
        chk("retired_total", 32'(retired_cnt), 32'(n_ho));
`else
        chk("retired_total", 32'(retired_cnt), 32'd0);
`endif

        // Reset mid-FETCH at pc 12.
        chk("pre_rst_addr", 32'(imem_addr), 32'd12);
        ack_wait = 5;
        reset = 1'b1;
        tick();
        chk("mid_rst_req", 32'(imem_req), 32'd0);
        chk("mid_rst_addr", 32'(imem_addr), 32'd0);
        chk("mid_rst_retired", 32'(retired_cnt), 32'd0);
        chk("mid_rst_err", 32'(addr_err), 32'd0);
        reset = 1'b0;
        ack_wait = 0;
        tick();
        chk("post_rst_idle", 32'(busy), 32'd0);
        run = 1'b1;
        tick();
        run = 1'b0;
        for (int i = 0; i < 10; i++) issue_one(AW'(i), 1'b0, '0, i == 9);
`ifdef FETCH_PERF_EN
        chk("retired_10", 32'(retired_cnt), 32'd10);
`else
        chk("retired_10", 32'(retired_cnt), 32'd0);
`endif
        chk("final_halted", 32'(busy), 32'd0);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Controller that sequences the CPU's program counter and instruction fetch. It owns the PC register and drives instruction-memory read requests over a req/ack handshake. Each fetched instruction goes to the decode stage over a valid/ready handshake, and branch/jump redirects are applied at that handshake. It sits between instruction memory and the decoder and replaces a free-running PC.

## Interface
Parameters:
- ADDR_W, 6, PC/address width
- DATA_W, 32, instruction width
- DEPTH, 64, number of instruction words (must be ≤ 2**ADDR_W); last valid address is DEPTH-1

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- run  in  1  start/resume fetching (level, sampled in IDLE/HALTED)
- halt_req  in  1  stop after current instruction hand-off (level)
- imem_req  out  1  instruction read request
- imem_addr  out  ADDR_W  read address (= pc)
- imem_ack  in  1  read data valid this cycle
- imem_rdata  in  DATA_W  instruction word
- instr_valid  out  1  instr/instr_pc valid to decoder
- instr_ready  in  1  decoder accepts instruction
- instr  out  DATA_W  registered instruction
- instr_pc  out  ADDR_W  address of instr
- redirect_valid  in  1  branch/jump taken (sampled only on the hand-off cycle)
- redirect_addr  in  ADDR_W  target address
- busy  out  1  high in FETCH or ISSUE
- addr_err  out  1  sticky: out-of-range redirect seen
- retired_cnt  out  16  retired instruction count (see Configuration)

Clock clk; reset reset, synchronous, active-high.

## Operation
- States: IDLE, FETCH, ISSUE, HALTED.
- IDLE: `run` → FETCH.
- FETCH: imem_req=1, imem_addr=pc held stable. `imem_ack` → capture imem_rdata into instr, pc into instr_pc → ISSUE. halt_req does not abort an outstanding request.
- ISSUE: instr_valid=1; instr/instr_pc held stable until `instr_ready`. Hand-off cycle (valid && ready):
  - Redirect taken (redirect_valid=1): pc ← redirect_addr.
    - If redirect_addr ≥ DEPTH: pc ← 0 and addr_err ← 1.
  - No redirect: pc ← (pc == DEPTH-1) ? 0 : pc+1.
  - Next state: HALTED if halt_req=1, else FETCH.
- HALTED: outputs idle, pc retained. `run` → FETCH at the retained pc.
- redirect_valid outside the hand-off cycle is ignored.
- Reset values: state IDLE, pc 0, imem_req 0, instr_valid 0, instr 0, instr_pc 0, busy 0, addr_err 0, retired_cnt 0.
- Reset mid-operation: an outstanding request is abandoned, and any late imem_ack is ignored because the state is IDLE.

## Timing
- run high in cycle N (IDLE) → imem_req=1 in cycle N+1.
- imem_ack may arrive in the same cycle imem_req rises (zero-wait memory).
- imem_ack in cycle M → instr_valid=1 in cycle M+1.
- Hand-off in cycle K → imem_req=1 with the new imem_addr in cycle K+1; instr_valid=0 in K+1.
- Throughput: at most one instruction per 2 cycles.
- All outputs are registered or decoded from registered state; there are no combinational paths from inputs to outputs.

## Configuration
- FETCH_PERF_EN defined:
  - retired_cnt is a 16-bit counter that increments on every hand-off.
  - It wraps 0xFFFF → 0 and resets to 0.
- FETCH_PERF_EN undefined: the counter is not synthesized and retired_cnt is tied to 0.

## Structure
- Package fetch_pkg: state enum typedef (fetch_state_t), default ADDR_W/DATA_W/DEPTH constants.
- Sub-module fetch_pc_next:
  - Combinational next-pc selection: increment with wrap at DEPTH-1, redirect, out-of-range clamp to 0.
  - Outputs next_pc and range_err.
- Top: FSM, PC/instr registers, optional counter.

## Test plan
- Reset, then run=1, zero-wait ack, instr_ready tied high → imem_addr sequence 0,1,2,3; instr_valid high every other cycle; instr_pc matches the address whose data was captured.
- DEPTH=64: retire 64 instructions → address after 63 is 0; addr_err stays 0.
- Hand-off at pc=5 with redirect_valid=1, redirect_addr=20 → next imem_addr=20. With DEPTH=40, redirect_addr=45 → next imem_addr=0 and addr_err=1 until reset.
- imem_ack delayed 3 cycles → imem_addr stable for all 4 request cycles; instr_valid rises the cycle after ack. instr_ready held low 2 cycles → instr unchanged.
- halt_req=1 during ISSUE at pc=7 → after the hand-off: HALTED, imem_req=0, busy=0. run=1 → imem_addr=8 next cycle.
- reset asserted mid-FETCH at pc=12 → next cycle imem_req=0, pc=0, retired_cnt=0. With FETCH_PERF_EN, 10 hand-offs → retired_cnt=10; without it, retired_cnt stays 0.
